// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, baud rate codes
// and the 50 MHz half-period divisors used by the baud generator.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } tx_state_e;

   localparam logic [1:0] BAUD24  = 2'b00;
   localparam logic [1:0] BAUD48  = 2'b01;
   localparam logic [1:0] BAUD96  = 2'b10;
   localparam logic [1:0] BAUD192 = 2'b11;

   // Terminal counts of the generator's down-counter; baud_clk toggles once
   // per (divisor + 1) clocks, so one bit lasts 2 * (divisor + 1) clocks.
   localparam int unsigned DIV24  = 10417;
   localparam int unsigned DIV48  = 5208;
   localparam int unsigned DIV96  = 2604;
   localparam int unsigned DIV192 = 1302;

   function automatic int unsigned baud_divisor(input logic [1:0] code);
      int unsigned div;
      case (code)
         BAUD24:  div = DIV24;
         BAUD48:  div = DIV48;
         BAUD96:  div = DIV96;
         default: div = DIV192;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/uart_tx_arb.sv
// Two-way fixed-priority arbiter: channel 0 wins unless channel 1 has been
// passed over STARVE_MAX times in a row while waiting.
module uart_tx_arb #(
   parameter int STARVE_MAX = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [SW-1:0] starve_cnt;
   logic          starved;

   assign starved = (starve_cnt == SW'(STARVE_MAX));

   always_comb begin
      grant = 2'b00;
      if (accept) begin
         if (valid[1] && (!valid[0] || starved)) begin
            grant = 2'b10;
         end else if (valid[0]) begin
            grant = 2'b01;
         end
      end
   end

   // Counts only the channel-0 wins that actually kept channel 1 waiting.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (grant[1]) begin
         starve_cnt <= '0;
      end else if (grant[0] && valid[1] && !starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shared UART transmit controller: arbitrates the control and bulk channels,
// serializes the granted byte on bit strobes, and owns the baud rate select.
//
// state  | meaning
// IDLE   | line high; baud changes and new grants accepted here
// ALIGN  | byte captured, waiting for the next bit strobe
// START  | driving the start bit
// DATA   | driving payload bits, LSB first
// PARITY | driving the parity bit (only when parity was enabled at accept)
// STOP   | driving the stop bit; busy drops when it ends
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int         DATA_W     = 8,
   parameter int         STARVE_MAX = 2,
   parameter logic [1:0] RESET_BAUD = BAUD96
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              baud_clk,
   output logic [1:0]        baud_rate_out,
   input  logic              cfg_valid,
   input  logic [1:0]        cfg_baud,
   output logic              cfg_ready,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              parity_en,
   input  logic              parity_odd,
   output logic              tx,
   output logic              busy,
   output logic              grant_id
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   tx_state_e         state;
   logic              baud_clk_q;
   logic              bit_stb;
   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  bit_cnt;
   logic              par_en_q;
   logic              par_bit_q;
   logic              arb_accept;
   logic [1:0]        grant;
   logic [DATA_W-1:0] grant_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         baud_clk_q <= 1'b0;
      end else begin
         baud_clk_q <= baud_clk;
      end
   end

   assign bit_stb = baud_clk & ~baud_clk_q;

   // A pending cfg request takes the IDLE cycle, so no grant is offered then.
   assign cfg_ready  = (state == ST_IDLE);
   assign arb_accept = cfg_ready && !cfg_valid;

   uart_tx_arb #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .valid   ({req1_valid, req0_valid}),
      .accept  (arb_accept),
      .grant   (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign grant_data = grant[1] ? req1_data : req0_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         tx            <= 1'b1;
         busy          <= 1'b0;
         grant_id      <= 1'b0;
         baud_rate_out <= RESET_BAUD;
         shift_q       <= '0;
         bit_cnt       <= '0;
         par_en_q      <= 1'b0;
         par_bit_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  baud_rate_out <= cfg_baud;
               end else if (|grant) begin
                  shift_q   <= grant_data;
                  par_en_q  <= parity_en;
                  par_bit_q <= ^grant_data ^ parity_odd;
                  grant_id  <= grant[1];
                  busy      <= 1'b1;
                  state     <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               bit_cnt <= '0;
               if (bit_stb) begin
                  tx    <= 1'b0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (bit_stb) begin
                  tx      <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_cnt <= CNT_W'(1);
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_stb) begin
                  if (bit_cnt == CNT_W'(DATA_W)) begin
                     if (par_en_q) begin
                        tx    <= par_bit_q;
                        state <= ST_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                     end
                  end else begin
                     tx      <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_stb) begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_stb) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a sampling UART receiver and an arbitration
// model judge frames, grants, baud-change hold-off, reset and real timing.
module tb_uart_tx_scheduler;

   localparam int STARVE = 2;
   localparam int FAST_P = 8;
   localparam int REAL_P = 2 * (1302 + 1);

   logic       clock = 1'b0;
   logic       reset_n;
   logic       baud_clk = 1'b0;
   logic [1:0] baud_rate_out;
   logic       cfg_valid;
   logic [1:0] cfg_baud;
   logic       cfg_ready;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       parity_en;
   logic       parity_odd;
   logic       tx;
   logic       busy;
   logic       grant_id;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   bit_p = FAST_P;
   int   scnt = 0;
   int   busy_fall = 0;
   int   overlaps = 0;
   int   gen_cnt = 0;
   logic real_mode = 1'b0;
   logic busy_prev = 1'b0;
   int   acc_q[$];

   uart_tx_scheduler dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .baud_clk      (baud_clk),
      .baud_rate_out (baud_rate_out),
      .cfg_valid     (cfg_valid),
      .cfg_baud      (cfg_baud),
      .cfg_ready     (cfg_ready),
      .req0_valid    (req0_valid),
      .req0_data     (req0_data),
      .req0_ready    (req0_ready),
      .req1_valid    (req1_valid),
      .req1_data     (req1_data),
      .req1_ready    (req1_ready),
      .parity_en     (parity_en),
      .parity_odd    (parity_odd),
      .tx            (tx),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Baud generator stand-in: fast fixed pacing, or the real 50 MHz divisors.
   function automatic int half_len(input logic rm, input logic [1:0] code);
      if (!rm) return FAST_P / 2;
      case (code)
         2'b00:   return 10417 + 1;
         2'b01:   return 5208 + 1;
         2'b10:   return 2604 + 1;
         default: return 1302 + 1;
      endcase
   endfunction

   always @(posedge clock) begin
      if (gen_cnt == 0) begin
         baud_clk <= ~baud_clk;
         gen_cnt  <= half_len(real_mode, baud_rate_out) - 1;
      end else begin
         gen_cnt <= gen_cnt - 1;
      end
   end

   always @(negedge clock) begin
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall = cyc;
      busy_prev = busy;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
         acc_q.push_back(req1_ready === 1'b1 ? 1 : 0);
         if ((req0_ready === 1'b1 && req1_ready === 1'b1) || cfg_valid === 1'b1) overlaps++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic arb_predict(input logic v0, input logic v1, output int w);
      w = (v1 && (!v0 || scnt == STARVE)) ? 1 : 0;
      if (w == 1) scnt = 0;
      else if (v1 && scnt < STARVE) scnt++;
   endtask

   task automatic get_accept(input string tag, input int exp);
      int n = 0;
      int ch = -1;
      while (acc_q.size() == 0 && n < 16 * bit_p) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (acc_q.size() != 0) ch = acc_q.pop_front();
      check({tag, "_grant"}, ch, exp);
   endtask

   task automatic rx_frame(input logic pen, output logic [7:0] d, output logic pb,
                           output logic sb, output logic stb, output int fc, output logic ok);
      int n = 0;
      ok = 1'b0; d = '0; pb = 1'b0; sb = 1'b1; stb = 1'b0; fc = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tx !== 1'b0 && n < 16 * bit_p);
      if (tx === 1'b0) begin
         fc = cyc;
         repeat (bit_p / 2) @(negedge clock);
         sb = tx;
         for (int i = 0; i < 8; i++) begin
            repeat (bit_p) @(negedge clock);
            d[i] = tx;
         end
         if (pen) begin
            repeat (bit_p) @(negedge clock);
            pb = tx;
         end
         repeat (bit_p) @(negedge clock);
         stb = tx;
         ok = 1'b1;
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] d, input logic pen, input logic podd);
      logic [7:0] rd;
      logic pb, sb, stb, ok;
      int fc;
      rx_frame(pen, rd, pb, sb, stb, fc, ok);
      check({tag, "_rx"}, ok, 1);
      if (ok) begin
         check({tag, "_start"}, sb, 0);
         check({tag, "_data"}, rd, d);
         if (pen) check({tag, "_parity"}, pb, ($countones(d) + podd) % 2);
         check({tag, "_stop"}, stb, 1);
         repeat (bit_p / 2 + 2) @(negedge clock);
         check({tag, "_busy_len"}, busy_fall - fc, (pen ? 11 : 10) * bit_p);
      end
   endtask

   initial begin
      int w;
      int n;
      int viol;
      int c0, c1, f2, last_rise;
      logic seen_idle, prev, v0, v1, pe, po;
      logic [7:0] d0, d1;

      reset_n = 1'b0; cfg_valid = 1'b0; cfg_baud = 2'b00;
      req0_valid = 1'b0; req0_data = '0; req1_valid = 1'b0; req1_data = '0;
      parity_en = 1'b0; parity_odd = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_gid", grant_id, 0);
      check("rst_baud", baud_rate_out, 2'b10);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);

      // Single bulk frame; parity inputs flipped after accept must not matter
      req1_data = 8'hA5; parity_en = 1'b0; parity_odd = 1'b0; req1_valid = 1'b1;
      arb_predict(1'b0, 1'b1, w);
      get_accept("single", w);
      @(posedge clock); #1;
      req1_valid = 1'b0; parity_en = 1'b1; parity_odd = 1'b1;
      check("single_gid", grant_id, 1);
      check_frame("single", 8'hA5, 1'b0, 1'b0);
      check("single_accepts", acc_q.size(), 0);

      // Priority channel with even parity
      req0_data = 8'h07; parity_en = 1'b1; parity_odd = 1'b0; req0_valid = 1'b1;
      arb_predict(1'b1, 1'b0, w);
      get_accept("parity", w);
      @(posedge clock); #1;
      req0_valid = 1'b0; parity_en = 1'b0; parity_odd = 1'b1;
      check("parity_gid", grant_id, 0);
      check_frame("parity", 8'h07, 1'b1, 1'b0);

      // Both channels held valid: starvation relief order
      req0_data = 8'h11; req1_data = 8'h22; parity_en = 1'b0; parity_odd = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         arb_predict(1'b1, 1'b1, w);
         get_accept("starve", w);
         @(posedge clock); #1;
         if (k == 5) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         check("starve_gid", grant_id, w);
         check_frame("starve", (w == 1) ? 8'h22 : 8'h11, 1'b0, 1'b0);
      end

      // Random requests, bytes and parity settings
      for (int i = 0; i < 10; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v1 = 1'b1;
         d0 = 8'($urandom); d1 = 8'($urandom);
         pe = 1'($urandom_range(0, 1)); po = 1'($urandom_range(0, 1));
         req0_data = d0; req1_data = d1; parity_en = pe; parity_odd = po;
         req0_valid = v0; req1_valid = v1;
         arb_predict(v0, v1, w);
         get_accept("rand", w);
         @(posedge clock); #1;
         req0_valid = 1'b0; req1_valid = 1'b0; parity_en = ~pe; parity_odd = ~po;
         check("rand_gid", grant_id, w);
         check_frame("rand", (w == 1) ? d1 : d0, pe, po);
      end

      // Baud change requested mid-frame is held until the frame ends
      req1_data = 8'h3C; parity_en = 1'b0; parity_odd = 1'b0; req1_valid = 1'b1;
      arb_predict(1'b0, 1'b1, w);
      get_accept("cfgbusy", w);
      @(posedge clock); #1;
      req1_valid = 1'b0;
      repeat (3 * bit_p) @(negedge clock);
      cfg_valid = 1'b1; cfg_baud = 2'b11; req1_data = 8'h5A; req1_valid = 1'b1;
      viol = 0; n = 0;
      do begin
         @(negedge clock);
         n++;
         if (busy === 1'b1 && (cfg_ready !== 1'b0 || baud_rate_out !== 2'b10)) viol++;
      end while (busy !== 1'b0 && n < 20 * bit_p);
      check("cfgbusy_hold", viol, 0);
      check("cfgbusy_idle_busy", busy, 0);
      check("cfgbusy_cfg_ready", cfg_ready, 1);
      check("cfgbusy_baud_kept", baud_rate_out, 2'b10);
      check("cfgbusy_no_grant", req1_ready, 0);
      @(posedge clock); #1;
      cfg_valid = 1'b0;
      @(negedge clock);
      check("cfgbusy_baud_new", baud_rate_out, 2'b11);
      #1;
      arb_predict(1'b0, 1'b1, w);
      get_accept("cfgnext", w);
      @(posedge clock); #1;
      req1_valid = 1'b0;
      check_frame("cfgnext", 8'h5A, 1'b0, 1'b0);

      // Reset in the middle of data bit 3
      req1_data = 8'hF0; req1_valid = 1'b1;
      arb_predict(1'b0, 1'b1, w);
      get_accept("rstmid", w);
      @(posedge clock); #1;
      req1_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tx !== 1'b0 && n < 16 * bit_p);
      repeat (4 * bit_p + bit_p / 2) @(negedge clock);
      check("rstmid_d3", tx, 0);
      #2 reset_n = 1'b0;
      #1;
      check("rstmid_tx", tx, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_baud", baud_rate_out, 2'b10);
      check("rstmid_cfg_ready", cfg_ready, 1);
      scnt = 0;
      acc_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      req1_data = 8'h96; parity_en = 1'b1; parity_odd = 1'b1; req1_valid = 1'b1;
      arb_predict(1'b0, 1'b1, w);
      get_accept("after_rst", w);
      @(posedge clock); #1;
      req1_valid = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
      check_frame("after_rst", 8'h96, 1'b1, 1'b1);

      // Real generator at 19200: start-bit width and inter-frame gap
      @(negedge clock);
      cfg_valid = 1'b1; cfg_baud = 2'b11;
      @(posedge clock); #1;
      cfg_valid = 1'b0;
      @(negedge clock);
      check("real_baud", baud_rate_out, 2'b11);
      real_mode = 1'b1;
      bit_p = REAL_P;
      req1_data = 8'h55; parity_en = 1'b0; req1_valid = 1'b1;
      arb_predict(1'b0, 1'b1, w);
      get_accept("real1", w);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tx !== 1'b0 && n < 4 * REAL_P);
      c0 = cyc;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tx !== 1'b1 && n < 4 * REAL_P);
      c1 = cyc;
      check("real_start_width", c1 - c0, REAL_P);
      last_rise = c1; seen_idle = 1'b0; f2 = -1; prev = 1'b1; n = 0;
      while (f2 < 0 && n < 14 * REAL_P) begin
         @(negedge clock);
         n++;
         if (busy === 1'b0) seen_idle = 1'b1;
         if (prev === 1'b0 && tx === 1'b1) last_rise = cyc;
         if (seen_idle && prev === 1'b1 && tx === 1'b0) f2 = cyc;
         prev = tx;
      end
      req1_valid = 1'b0;
      check("real_gap", (f2 >= 0) && (f2 - last_rise >= REAL_P), 1);
      arb_predict(1'b0, 1'b1, w);
      get_accept("real2", w);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tx !== 1'b1 && n < 4 * REAL_P);
      check("real_start_width2", cyc - f2, REAL_P);

      check("no_overlap", overlaps, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Controller for the shared UART transmit path.
- Arbitrates two byte requesters: req0 is the priority/control channel (XON/XOFF, status), and req1 is the bulk channel from the APB data FIFO.
- Serializes the granted byte as a UART frame, paced by the baud generator's toggling baud_clk.
- Owns the baud-rate select driven into the generator and allows rate changes only between frames.

Parameters:
- DATA_W, 8, payload bits per frame.
- STARVE_MAX, 2, consecutive req0 wins while req1 waits before req1 is forced.
- RESET_BAUD, 2'b10, reset value of baud_rate_out (00=2400, 01=4800, 10=9600, 11=19200).

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- baud_clk  in  1  toggling output of the baud generator, synchronous to clock
- baud_rate_out  out  2  rate select driven to the baud generator
- cfg_valid  in  1  baud change request
- cfg_baud  in  2  requested rate code
- cfg_ready  out  1  high only in IDLE; a transfer occurs when cfg_valid&&cfg_ready
- req0_valid  in  1  priority channel valid
- req0_data  in  DATA_W  priority byte
- req0_ready  out  1  accept strobe, priority channel
- req1_valid  in  1  bulk channel valid
- req1_data  in  DATA_W  bulk byte
- req1_ready  out  1  accept strobe, bulk channel
- parity_en  in  1  parity bit enable, sampled at accept
- parity_odd  in  1  1=odd parity, 0=even, sampled at accept
- tx  out  1  serial line, idle high
- busy  out  1  high from accept through end of stop bit
- grant_id  out  1  source of the current/last frame

Behaviour:
- Reset: tx=1, busy=0, grant_id=0, baud_rate_out=RESET_BAUD, readies=0, cfg_ready=1, starve counter=0, FSM=IDLE. Reset mid-frame forces tx=1 immediately.
- Bit strobe: bit_stb = baud_clk & ~baud_clk_q, with baud_clk_q registered. One bit period equals two baud_clk half-periods. At 19200 this is 2*1303 = 2606 clocks.
- FSM states: IDLE, ALIGN, START, DATA, PARITY, STOP.
- Priority in IDLE, evaluated each cycle:
  - cfg transfer first: baud_rate_out <= cfg_baud on the next edge. No grant is issued in that cycle.
  - Otherwise the arbiter decides.
- Arbiter:
  - req0 wins over req1, except that req1 wins when the starve counter equals STARVE_MAX and req1_valid=1.
  - The counter increments on each req0 grant made while req1_valid=1, and clears on any req1 grant.
  - It saturates at STARVE_MAX.
- Accept:
  - reqN_ready is combinational, high only in IDLE for the winner.
  - The data byte, parity_en and parity_odd are captured on the accept edge.
  - grant_id <= N, busy <= 1, FSM goes to ALIGN.
  - At most one ready is high per cycle, and none while cfg_valid=1.
- Frame sequencing; every transition below occurs only on bit_stb:
  - ALIGN→START: tx <= 0.
  - START→DATA: tx <= d[0].
  - DATA shifts LSB first. After DATA_W bits it goes to PARITY if parity_en, else STOP.
  - PARITY drives tx = ^d ^ parity_odd.
  - STOP drives tx <= 1 for one full bit period.
  - On the bit_stb ending STOP: FSM → IDLE, busy <= 0.
- Back-to-back frames: a new accept may occur in the first IDLE cycle. The next start bit is driven at the following bit_stb, so the line sees exactly one stop bit of idle at minimum.
- Coincident events:
  - bit_stb during IDLE is ignored.
  - A cfg request arriving while busy is held off with cfg_ready=0 until IDLE. It is then serviced before any pending req.
- Width rules:
  - The bit counter is $clog2(DATA_W+1) wide and wraps only via FSM reset to 0 in ALIGN.
  - The starve counter is $clog2(STARVE_MAX+1) wide.
- baud_rate_out never changes while busy=1.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_state_e.
  - baud code constants BAUD24/48/96/192.
  - The 50 MHz divisor constants (10417/5208/2604/1302), which are shared with the generator.
- One sub-module, uart_tx_arb: 2-way fixed-priority arbiter with starvation counter. Inputs are valids and the accept strobe; output is a one-hot grant.

Test Plan:
- Single frame: req1 sends 0xA5, no parity. tx over successive bit_stb reads 0,1,0,1,0,0,1,0,1,1. busy drops on the 10th strobe. req1_ready is high exactly one cycle.
- Parity: req0 sends 0x07 with parity_en=1 and parity_odd=0. The parity bit is 1, the frame is 11 bits, and grant_id=0.
- Starvation: req0 and req1 are held valid continuously. Grant order is 0,0,1,0,0,1, and the starve counter returns to 0 after each req1 grant.
- Baud change while busy: cfg_valid with 2'b11 asserted mid-frame. cfg_ready stays 0 and baud_rate_out stays 2'b10 until the stop bit ends. baud_rate_out becomes 11 one cycle later, with no grant that cycle even though req1_valid=1.
- Reset mid-frame: reset_n pulled low during DATA bit 3. tx=1, busy=0 and baud_rate_out=2'b10 immediately. After release, a new req1 frame completes correctly.
- Real generator, rate 11: measured start-bit width is 2606 clocks ±0, and back-to-back frames show a stop/idle gap of ≥2606 clocks.
